// File: rtl/roc_aer_out_ctrl.sv
// roc_aer_out_ctrl: turns sorted encoder indices into 4-phase AER events, with a per-image count and a sticky timeout flag.
// Optional macro ROC_AER_ACK_SYNC_EN routes AEROUT_ACK through a 2-flop synchronizer for a core on another clock.
module roc_aer_out_ctrl #(
   parameter int INDEX_BITS     = 8,
   parameter int ADDR_BITS      = 10,
   parameter int ADDR_OFFSET    = 0,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_BITS       = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [INDEX_BITS-1:0] NEXT_INDEX,
   input  logic                  FOUND_NEXT_INDEX,
   input  logic                  CNT_CLR,
   output logic                  AEROUT_CTRL_BUSY,
   output logic [ADDR_BITS-1:0]  AEROUT_ADDR,
   output logic                  AEROUT_REQ,
   input  logic                  AEROUT_ACK,
   output logic [CNT_BITS-1:0]   EVENT_CNT,
   output logic                  TIMEOUT_ERR
);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK_LOW} state_t;
   state_t r_state, w_next;
   logic [TW-1:0] r_timer;
   logic [ADDR_BITS-1:0] r_addr;
   logic [CNT_BITS-1:0] r_cnt;
   logic r_err;
   logic w_ack, w_tmo, w_done, w_abort;
`ifdef ROC_AER_ACK_SYNC_EN
   logic [1:0] r_ack_sync;
   always_ff @(posedge CLK or posedge RST)
      if (RST) r_ack_sync <= '0;
      else r_ack_sync <= {r_ack_sync[0], AEROUT_ACK};
   assign w_ack = r_ack_sync[1];
`else
   assign w_ack = AEROUT_ACK;
`endif
   assign w_tmo = r_timer == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge CLK or posedge RST)
      if (RST) r_state <= S_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next  = r_state;
      w_done  = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         S_IDLE:    w_next = FOUND_NEXT_INDEX ? S_REQ : S_IDLE;
         S_REQ: begin
            w_abort = !w_ack && w_tmo;
            w_next  = w_ack ? S_ACK_LOW : w_abort ? S_IDLE : S_REQ;
         end
         S_ACK_LOW: begin
            w_done  = !w_ack;
            w_abort = w_ack && w_tmo;
            w_next  = (w_done || w_abort) ? S_IDLE : S_ACK_LOW;
         end
         default:   w_next = S_IDLE;
      endcase
   end
   // BUSY includes FOUND so the encoder sees back-pressure in the cycle it presents an index
   always_comb begin
      AEROUT_REQ       = r_state == S_REQ;
      AEROUT_CTRL_BUSY = (r_state != S_IDLE) || FOUND_NEXT_INDEX;
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         r_timer <= '0;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_timer <= (r_state == S_IDLE || w_next != r_state) ? '0 : r_timer + TW'(1);
         if (r_state == S_IDLE && FOUND_NEXT_INDEX)
            r_addr <= ADDR_BITS'(ADDR_OFFSET) + ADDR_BITS'(NEXT_INDEX);
         r_cnt <= CNT_CLR ? '0 : (w_done && r_cnt != '1) ? r_cnt + CNT_BITS'(1) : r_cnt;
         r_err <= !CNT_CLR && (r_err || w_abort);
      end
   assign AEROUT_ADDR = r_addr;
   assign EVENT_CNT   = r_cnt;
   assign TIMEOUT_ERR = r_err;
endmodule

// File: tb/tb_roc_aer_out_ctrl.sv
// tb_roc_aer_out_ctrl: randomized handshake bench with a transaction-level model of address, count and timeout flag.
module tb_roc_aer_out_ctrl;
   localparam int IB = 8, AB = 10, OFF = 1020, TO = 16, CB = 4;
`ifdef ROC_AER_ACK_SYNC_EN
   localparam int S = 1;
`else
   localparam int S = 0;
`endif
   logic clk = 0, rst = 1, found = 0, clr = 0, ack = 0;
   logic [IB-1:0] idx = '0;
   logic busy, req, err;
   logic [AB-1:0] addr;
   logic [CB-1:0] cnt;
   int checks = 0, fails = 0, m_cnt = 0, m_err = 0;

   roc_aer_out_ctrl #(.INDEX_BITS(IB), .ADDR_BITS(AB), .ADDR_OFFSET(OFF), .TIMEOUT_CYCLES(TO), .CNT_BITS(CB)) dut (
      .CLK(clk), .RST(rst), .NEXT_INDEX(idx), .FOUND_NEXT_INDEX(found), .CNT_CLR(clr),
      .AEROUT_CTRL_BUSY(busy), .AEROUT_ADDR(addr), .AEROUT_REQ(req), .AEROUT_ACK(ack),
      .EVENT_CNT(cnt), .TIMEOUT_ERR(err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // mode 0: normal, 1: ACK never rises, 2: ACK never falls
   task automatic run_event(input int i, input int dly, input int mode, input bit poke, input bit clr_end);
      int w, w2, ea;
      ea = (OFF + i) % (1 << AB);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      idx = IB'(i);
      found = 1;
      #1 chk("busy_same_cycle", busy, 1);
      @(negedge clk);
      found = 0;
      chk("req_latency", req, 1);
      chk("addr_capture", addr, ea);
      w = 0;
      while (req && w < 40) begin
         if (mode != 1 && w == dly) ack = 1;
         found = poke && w == 1;
         if (found) idx = 9;
         w++;
         @(negedge clk);
      end
      found = 0;
      chk("req_width", w, mode == 1 ? TO : dly + 1 + 2 * S);
      w2 = 0;
      while (busy && w2 < 40) begin
         if (mode == 0 && w2 == dly) ack = 0;
         clr = clr_end && mode == 0 && w2 == dly + 2 * S;
         w2++;
         @(negedge clk);
      end
      clr = 0;
      chk("acklow_width", w2, mode == 0 ? dly + 1 + 2 * S : mode == 1 ? 0 : TO);
      if (clr_end) begin
         m_cnt = 0;
         m_err = 0;
      end else if (mode == 0) m_cnt = (m_cnt == (1 << CB) - 1) ? m_cnt : m_cnt + 1;
      else m_err = 1;
      if (mode != 0) begin
         ack = 0;
         repeat (3) @(negedge clk);
      end
      chk("req_after", req, 0);
      chk("addr_held", addr, ea);
      chk("event_cnt", cnt, m_cnt);
      chk("timeout_err", err, m_err);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clr = 1;
      @(negedge clk);
      clr = 0;
      m_cnt = 0;
      m_err = 0;
      chk("clr_cnt", cnt, 0);
      chk("clr_err", err, 0);
   endtask

   initial begin
      int order[7] = '{3, 0, 6, 1, 5, 2, 4};
      repeat (5) begin
         @(negedge clk);
         found = 1'($urandom);
         idx = IB'($urandom);
         ack = 1'($urandom);
         clr = 1'($urandom);
         #1;
         chk("rst_req", req, 0);
         chk("rst_addr", addr, 0);
         chk("rst_cnt", cnt, 0);
         chk("rst_err", err, 0);
         chk("rst_busy", busy, found);
      end
      found = 0; ack = 0; clr = 0;
      @(negedge clk);
      rst = 0;
      run_event(5, 1, 0, 0, 0);
      do_clear();
      foreach (order[k]) run_event(order[k], 1, 0, 0, 0);
      chk("stream_cnt", cnt, 7);
      run_event(6, 0, 0, 0, 0);
      chk("wrap_addr", addr, 2);
      run_event(1, 0, 1, 0, 0);
      run_event(2, 2, 0, 0, 0);
      chk("err_sticky", err, 1);
      do_clear();
      run_event(3, 1, 2, 0, 0);
      run_event(7, 2, 0, 0, 1);
      run_event(4, 3, 0, 1, 0);
      @(negedge clk);
      found = 1;
      idx = 4;
      @(negedge clk);
      found = 0;
      chk("mid_req", req, 1);
      rst = 1;
      #1;
      chk("mid_rst_req", req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cnt", cnt, 0);
      @(negedge clk);
      rst = 0;
      m_cnt = 0;
      m_err = 0;
      for (int k = 0; k < 30; k++)
         run_event(int'($urandom_range(0, 255)), int'($urandom_range(0, 8)),
                   (k % 7 == 3) ? 1 : (k % 11 == 5) ? 2 : 0, 0, 0);
      chk("saturated_cnt", cnt, (1 << CB) - 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/roc_aer_out_ctrl.md
Name: roc_aer_out_ctrl

Overview:
Downstream stage of the ROC encoder. It consumes each sorted pixel index (NEXT_INDEX qualified by FOUND_NEXT_INDEX) and converts it into one AER event on a 4-phase REQ/ACK output bus to the SNN core. AEROUT_CTRL_BUSY back-pressures the encoder while an event is in flight. The block also keeps a per-image event counter and a sticky handshake-timeout flag.

Parameters:
INDEX_BITS, 8, width of NEXT_INDEX from the encoder
ADDR_BITS, 10, width of the AER address bus; must be >= INDEX_BITS
ADDR_OFFSET, 0, constant added to the index to form the AER address (neuron base address)
TIMEOUT_CYCLES, 1024, maximum clock cycles allowed in one handshake phase before the event is aborted
CNT_BITS, 16, width of EVENT_CNT

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  asynchronous, active-high reset
NEXT_INDEX  in  INDEX_BITS  sorted pixel index from the encoder
FOUND_NEXT_INDEX  in  1  NEXT_INDEX valid; one-cycle pulse or held high
CNT_CLR  in  1  clears EVENT_CNT and TIMEOUT_ERR; tied to NEW_IMAGE at top level
AEROUT_CTRL_BUSY  out  1  back-pressure to the encoder
AEROUT_ADDR  out  ADDR_BITS  AER event address
AEROUT_REQ  out  1  AER request
AEROUT_ACK  in  1  AER acknowledge from the core
EVENT_CNT  out  CNT_BITS  events completed since the last clear
TIMEOUT_ERR  out  1  sticky flag: a handshake was aborted

Behaviour:
- Reset (async, any state): state=IDLE, AEROUT_REQ=0, AEROUT_ADDR=0, EVENT_CNT=0, TIMEOUT_ERR=0, timer=0. AEROUT_CTRL_BUSY=0 once FOUND_NEXT_INDEX=0. Reset mid-handshake drops REQ immediately. The in-flight event is lost and not counted.
- Busy definition: AEROUT_CTRL_BUSY = (state != IDLE) OR (state == IDLE AND FOUND_NEXT_INDEX). The combinational term guarantees that the encoder sees busy in the same cycle it presents an index.
- State IDLE:
  - If FOUND_NEXT_INDEX=1, capture AEROUT_ADDR <= ADDR_OFFSET + zero-extended NEXT_INDEX, computed modulo 2^ADDR_BITS, with wrap-around allowed.
  - Then go to REQ, clear the timer.
- State REQ:
  - AEROUT_REQ=1, registered, so it first asserts the cycle after capture. Latency from FOUND_NEXT_INDEX to REQ high is 1 cycle.
  - When the effective ACK is 1, deassert REQ and go to ACK_LOW, clear the timer.
- State ACK_LOW:
  - AEROUT_REQ=0.
  - When the effective ACK is 0, go to IDLE and increment EVENT_CNT.
  - AEROUT_CTRL_BUSY falls on the cycle IDLE is entered.
- AEROUT_ADDR is held stable from capture until the next capture.
- Timer:
  - Counts every cycle in REQ and ACK_LOW.
  - If it reaches TIMEOUT_CYCLES-1 without the awaited ACK level, set TIMEOUT_ERR=1, force REQ=0, and go to IDLE.
  - The aborted event is not counted. TIMEOUT_ERR stays set until CNT_CLR or RST.
- FOUND_NEXT_INDEX while not IDLE: ignored. No capture, no error; the encoder is required to honour BUSY.
- FOUND_NEXT_INDEX held high in IDLE: produces one event per pass through IDLE. A held-high level produces back-to-back events.
- EVENT_CNT saturates at 2^CNT_BITS-1.
- CNT_CLR: clears EVENT_CNT and TIMEOUT_ERR the next cycle.
  - It wins over a simultaneous increment or timeout; the result is 0/0.
  - It does not affect the handshake state.

Optional Feature:
Macro ROC_AER_ACK_SYNC_EN.
- Defined: AEROUT_ACK passes through a 2-flop synchronizer, reset to 0, before the FSM. The effective ACK lags the pin by 2 cycles, which adds 2 cycles to each phase response.
- Undefined: AEROUT_ACK is used directly, for a same-clock core.
- Timeout counting is identical in both builds.

Test Plan:
1. Reset check: hold RST=1 with random inputs -> REQ=0, ADDR=0, EVENT_CNT=0, TIMEOUT_ERR=0. Then pulse FOUND=1 with NEXT_INDEX=5 and ACK responder 2 cycles per phase -> BUSY=1 same cycle, REQ=1 next cycle, ADDR=5, EVENT_CNT=1 after ACK returns low, BUSY=0.
2. Stream of 7 indices 3,0,6,1,5,2,4 presented only while BUSY=0 -> exactly 7 REQ pulses, addresses in that order, EVENT_CNT=7.
3. ADDR_OFFSET=1020, ADDR_BITS=10, NEXT_INDEX=6 -> AEROUT_ADDR=2 (wrap).
4. ACK never rises with TIMEOUT_CYCLES=16 -> REQ drops 16 cycles after assertion, TIMEOUT_ERR=1, EVENT_CNT unchanged. A subsequent normal event completes and TIMEOUT_ERR stays 1 until CNT_CLR=1, which clears it to 0.
5. FOUND pulse with NEXT_INDEX=9 during REQ of event 4 -> ignored, no extra REQ, ADDR stays 4. Assert RST while REQ=1 -> REQ=0 immediately, state IDLE, EVENT_CNT=0.
6. With ROC_AER_ACK_SYNC_EN defined and zero-delay ACK responder -> REQ high for exactly 3 cycles, 6 cycles per full event.
